// File: rtl/lsu_queue_writer_if.sv
// rtl/lsu_queue_writer_if.sv - dispatch/reader-facing bundle of the LSU queue writer
interface lsu_queue_writer_if #(
  parameter int DATA_W = 113,
  parameter int DEPTH  = 16,
  parameter int ADDR_W = 4
);
  logic                    i_valid;
  logic                    o_ready;
  logic [DATA_W-1:0]       i_instr_113;
  logic [ADDR_W:0]         i_RdGray_5;
  logic [ADDR_W:0]         o_WrGray_5;
  logic [DEPTH*DATA_W-1:0] o_InstructionQueue_1808;
  logic [ADDR_W:0]         o_LsuCount_5;
  logic                    o_full;
  logic                    o_empty;

  modport master (
    output i_valid, i_instr_113, i_RdGray_5,
    input  o_ready, o_WrGray_5, o_InstructionQueue_1808, o_LsuCount_5, o_full, o_empty
  );

  modport slave (
    input  i_valid, i_instr_113, i_RdGray_5,
    output o_ready, o_WrGray_5, o_InstructionQueue_1808, o_LsuCount_5, o_full, o_empty
  );
endinterface

// File: rtl/lsu_queue_writer.sv
// rtl/lsu_queue_writer.sv - write side of the 16-entry LSU instruction queue
module lsu_queue_writer #(
  parameter int DATA_W = 113,
  parameter int DEPTH  = 16,
  parameter int ADDR_W = 4
) (
  input  logic               clk,
  input  logic               rst,
  lsu_queue_writer_if.slave  q
);
  localparam logic [ADDR_W:0] PTR_ONE = {{ADDR_W{1'b0}}, 1'b1};

  logic [ADDR_W:0]         wr_bin_q, wr_bin_d;
  logic [ADDR_W:0]         wr_gray_q, wr_gray_d;
  logic [ADDR_W:0]         sync1_q, sync2_q;
  logic [ADDR_W:0]         rd_bin;
  logic [ADDR_W:0]         full_gray;
  logic [DATA_W-1:0]       mem_q [DEPTH];
  logic [DEPTH*DATA_W-1:0] queue_flat;
  logic                    full;
  logic                    fire;

  // Reader pointer decoded from the synchronized Gray copy only.
  always_comb begin
    rd_bin = '0;
    for (int i = 0; i <= ADDR_W; i++) begin
      rd_bin[i] = ^(sync2_q >> i);
    end
  end

  assign full_gray = {~sync2_q[ADDR_W:ADDR_W-1], sync2_q[ADDR_W-2:0]};
  assign full      = (wr_gray_q == full_gray);
  assign fire      = q.i_valid & ~full;
  assign wr_bin_d  = wr_bin_q + PTR_ONE;
  assign wr_gray_d = wr_bin_d ^ (wr_bin_d >> 1);

  always_comb begin
    queue_flat = '0;
    for (int k = 0; k < DEPTH; k++) begin
      queue_flat[k*DATA_W +: DATA_W] = mem_q[k];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_bin_q  <= '0;
      wr_gray_q <= '0;
      sync1_q   <= '0;
      sync2_q   <= '0;
    end else begin
      sync1_q <= q.i_RdGray_5;
      sync2_q <= sync1_q;
      if (fire) begin
        wr_bin_q  <= wr_bin_d;
        wr_gray_q <= wr_gray_d;
      end
    end
  end

  // Entries are never cleared by reads; only the pointers mark them free.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < DEPTH; k++) begin
        mem_q[k] <= '0;
      end
    end else if (fire) begin
      mem_q[wr_bin_q[ADDR_W-1:0]] <= q.i_instr_113;
    end
  end

  assign q.o_ready                 = ~full;
  assign q.o_full                  = full;
  assign q.o_empty                 = (wr_gray_q == sync2_q);
  assign q.o_LsuCount_5            = wr_bin_q - rd_bin;
  assign q.o_WrGray_5              = wr_gray_q;
  assign q.o_InstructionQueue_1808 = queue_flat;
endmodule

// File: tb/tb_lsu_queue_writer.sv
// tb/tb_lsu_queue_writer.sv - randomized self-checking bench for lsu_queue_writer
module tb_lsu_queue_writer;
  localparam int DW = 113;
  localparam int DP = 16;
  localparam int AW = 4;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   checks = 0;
  int   errors = 0;
  bit   started = 1'b0;

  lsu_queue_writer_if #(.DATA_W(DW), .DEPTH(DP), .ADDR_W(AW)) q();

  lsu_queue_writer #(.DATA_W(DW), .DEPTH(DP), .ADDR_W(AW)) dut (
    .clk (clk),
    .rst (rst),
    .q   (q)
  );

  always #5 clk = ~clk;

  // Model: total writes since reset, stored entries, reader pointer seen two edges late.
  int            m_wtotal;
  logic [DW-1:0] m_mem [DP];
  logic [DW-1:0] exp_q [$];
  logic [4:0]    g1, g2;

  bit         rd_auto = 1'b0;
  int         rd_rate = 0;
  logic [4:0] rd_manual = '0;
  int         rd_r, wh1, wh2;

  function automatic logic [4:0] gray5(input int v);
    logic [4:0] b;
    b = v[4:0];
    return b ^ (b >> 1);
  endfunction

  function automatic logic [4:0] ungray(input logic [4:0] g);
    logic [4:0] bb;
    for (int b = 0; b < 32; b++) begin
      bb = b[4:0];
      if ((bb ^ (bb >> 1)) == g) return bb;
    end
    return '0;
  endfunction

  function automatic logic [4:0] m_cnt();
    logic [4:0] w;
    w = m_wtotal[4:0];
    return w - ungray(g2);
  endfunction

  function automatic bit m_full();
    return m_cnt() == 5'd16;
  endfunction

  function automatic logic [DW-1:0] entry(input int k);
    return q.o_InstructionQueue_1808[k*DW +: DW];
  endfunction

  function automatic logic [DW-1:0] rnd();
    logic [127:0] t;
    t = {$urandom, $urandom, $urandom, $urandom};
    return t[DW-1:0];
  endfunction

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  assign q.i_RdGray_5 = rd_auto ? gray5(rd_r) : rd_manual;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_wtotal = 0;
      for (int k = 0; k < DP; k++) m_mem[k] = '0;
      exp_q.delete();
      g1 = '0;
      g2 = '0;
    end else begin
      if (q.i_valid === 1'b1 && !m_full()) begin
        m_mem[m_wtotal % DP] = q.i_instr_113;
        exp_q.push_back(q.i_instr_113);
        m_wtotal++;
      end
      g2 = g1;
      g1 = q.i_RdGray_5;
    end
  end

  // Reader: consumes an entry only once it has been written for two cycles.
  always @(negedge clk or posedge rst) begin
    if (rst) begin
      rd_r = 0;
      wh1  = 0;
      wh2  = 0;
    end else begin
      if (rd_auto && rd_r < wh2 && $urandom_range(0, 99) < rd_rate) begin
        chk("read_data", entry(rd_r % DP), exp_q.pop_front());
        rd_r++;
      end
      wh2 = wh1;
      wh1 = m_wtotal;
    end
  end

  always @(negedge clk) begin
    if (started && !rst) begin
      chk("ready", q.o_ready, !m_full());
      chk("full", q.o_full, m_full());
      chk("empty", q.o_empty, m_cnt() == 5'd0);
      chk("count", q.o_LsuCount_5, m_cnt());
      chk("count_le16", q.o_LsuCount_5 <= 5'd16, 1'b1);
      chk("wrgray", q.o_WrGray_5, gray5(m_wtotal));
      for (int k = 0; k < DP; k++) chk("array", entry(k), m_mem[k]);
    end
  end

  task automatic wr_cycle(input logic v, input logic [DW-1:0] d);
    @(negedge clk);
    q.i_valid     = v;
    q.i_instr_113 = d;
  endtask

  task automatic chk_reset_values(input string tag);
    chk({tag, "_ready"}, q.o_ready, 1'b1);
    chk({tag, "_empty"}, q.o_empty, 1'b1);
    chk({tag, "_full"}, q.o_full, 1'b0);
    chk({tag, "_count"}, q.o_LsuCount_5, 5'd0);
    chk({tag, "_wrgray"}, q.o_WrGray_5, 5'b00000);
    chk({tag, "_array_zero"}, q.o_InstructionQueue_1808 == '0, 1'b1);
  endtask

  logic [DW-1:0] rec33;
  int            n;
  bit            pend33;

  initial begin
    q.i_valid     = 1'b0;
    q.i_instr_113 = '0;
    #1 rst = 1'b1;
    #1 chk_reset_values("reset");
    #1 rst = 1'b0;
    started = 1'b1;

    wr_cycle(1'b1, 113'h1);
    wr_cycle(1'b1, 113'h2);
    wr_cycle(1'b1, 113'h3);
    wr_cycle(1'b0, '0);
    #1;
    chk("basic_e0", entry(0), 113'h1);
    chk("basic_e1", entry(1), 113'h2);
    chk("basic_e2", entry(2), 113'h3);
    chk("basic_wrgray", q.o_WrGray_5, 5'b00010);
    chk("basic_count", q.o_LsuCount_5, 5'd3);
    chk("basic_empty", q.o_empty, 1'b0);

    repeat (13) wr_cycle(1'b1, rnd());
    wr_cycle(1'b0, '0);
    #1;
    chk("fill_full", q.o_full, 1'b1);
    chk("fill_ready", q.o_ready, 1'b0);
    chk("fill_wrgray", q.o_WrGray_5, 5'b11000);
    chk("fill_count", q.o_LsuCount_5, 5'd16);

    repeat (3) wr_cycle(1'b1, 113'hABC);
    wr_cycle(1'b0, '0);
    rd_manual = 5'b00001;
    #1;
    chk("hold_e0", entry(0), 113'h1);
    chk("hold_wrgray", q.o_WrGray_5, 5'b11000);
    @(negedge clk);
    #1 chk("drain_edge1_full", q.o_full, 1'b1);
    @(negedge clk);
    q.i_valid     = 1'b1;
    q.i_instr_113 = 113'hDEF;
    #1;
    chk("drain_edge2_full", q.o_full, 1'b0);
    chk("drain_count", q.o_LsuCount_5, 5'd15);
    chk("drain_ready", q.o_ready, 1'b1);
    wr_cycle(1'b0, '0);
    #1;
    chk("drain_write_e0", entry(0), 113'hDEF);
    chk("drain_refull", q.o_full, 1'b1);
    chk("drain_wrgray", q.o_WrGray_5, 5'b11001);

    @(negedge clk);
    #1 rst = 1'b1;
    rd_auto = 1'b1;
    rd_rate = 100;
    #1 rst = 1'b0;
    n = 0;
    pend33 = 1'b0;
    for (int c = 0; c < 400 && n < 40; c++) begin
      @(negedge clk);
      if (pend33) begin
        #1;
        chk("wrap_w33_e0", entry(0), rec33);
        chk("wrap_w33_wrgray", q.o_WrGray_5, 5'b00001);
        pend33 = 1'b0;
      end
      if (!m_full()) begin
        q.i_valid     = 1'b1;
        q.i_instr_113 = rnd();
        n++;
        if (n == 33) begin
          rec33  = q.i_instr_113;
          pend33 = 1'b1;
        end
      end else begin
        q.i_valid = 1'b0;
      end
    end
    wr_cycle(1'b0, '0);
    chk("wrap_done", n, 40);

    for (int c = 0; c < 300; c++) begin
      rd_rate = (c < 150) ? 25 : 60;
      wr_cycle($urandom_range(0, 99) < 70, rnd());
    end

    wr_cycle(1'b0, '0);
    rd_rate = 0;
    #1 rst = 1'b1;
    #1 rst = 1'b0;
    repeat (5) wr_cycle(1'b1, rnd());
    wr_cycle(1'b0, '0);
    #1 chk("mid_count5", q.o_LsuCount_5, 5'd5);
    #1 rst = 1'b1;
    #1 chk_reset_values("mid_reset");
    q.i_valid     = 1'b1;
    q.i_instr_113 = 113'h777;
    @(negedge clk);
    chk("in_reset_wrgray", q.o_WrGray_5, 5'b00000);
    chk("in_reset_array", q.o_InstructionQueue_1808 == '0, 1'b1);
    rst = 1'b0;
    q.i_instr_113 = 113'h5A5;
    wr_cycle(1'b0, '0);
    #1;
    chk("post_reset_e0", entry(0), 113'h5A5);
    chk("post_reset_wrgray", q.o_WrGray_5, 5'b00001);
    chk("post_reset_count", q.o_LsuCount_5, 5'd1);

    repeat (2) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
